// File: rtl/sample_pkg.sv
// sample_pkg: shared types and constants for the sample packer.
package sample_pkg;
    typedef enum logic [1:0] {EMPTY, HALF, WRITE} state_t;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W = 32;
    localparam logic [SAMPLE_W-1:0] PAD_HALF = 16'h0000;
endpackage

// File: rtl/sample_packer.sv
// sample_packer: packs pairs of 16-bit samples into 32-bit words and writes them
// to a circular buffer, with a 1-deep spare to absorb a sample during a write.
module sample_packer
    import sample_pkg::*;
#(
    parameter int MEM_SIZE = 4096,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                rx_valid,
    input  logic [SAMPLE_W-1:0] rx_data,
    input  logic                flush,
    input  logic                mem_ack,
    output logic                mem_we,
    output logic [WORD_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic [WORD_W-1:0]   word_count,
    output logic                wrapped,
    output logic                overflow,
    output logic                busy
);
    localparam int PW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
    localparam logic [PW-1:0] PTR_MAX = PW'(MEM_SIZE - 1);

    state_t              r_state, w_next;
    logic [SAMPLE_W-1:0] r_upper, r_lower, r_spare;
    logic                r_spare_v, r_wrapped, r_overflow;
    logic [PW-1:0]       r_ptr;
    logic [WORD_W-1:0]   r_count;
    logic                w_acc, w_last;

    assign w_acc  = rx_valid & enable;
    assign w_last = r_ptr == PTR_MAX;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= EMPTY;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   w_next = w_acc ? HALF : EMPTY;
            HALF:    w_next = (w_acc | flush) ? WRITE : HALF;
            WRITE:   w_next = !mem_ack ? WRITE : (r_spare_v | w_acc) ? HALF : EMPTY;
            default: w_next = EMPTY;
        endcase
    end

    always_comb begin
        mem_we     = r_state == WRITE;
        busy       = r_state != EMPTY;
        mem_addr   = BASE_ADDR + WORD_W'(r_ptr);
        mem_wdata  = {r_upper, r_lower};
        word_count = r_count;
        wrapped    = r_wrapped;
        overflow   = r_overflow;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_upper    <= '0;
            r_lower    <= '0;
            r_spare    <= '0;
            r_spare_v  <= 1'b0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: if (w_acc) r_upper <= rx_data;
                HALF:  if (w_acc | flush) r_lower <= w_acc ? rx_data : PAD_HALF;
                WRITE: begin
                    if (mem_ack) begin
                        r_count   <= r_count + WORD_W'(1);
                        r_ptr     <= w_last ? '0 : r_ptr + PW'(1);
                        r_wrapped <= r_wrapped | w_last;
                        r_spare_v <= 1'b0;
                        r_upper   <= r_spare_v ? r_spare : w_acc ? rx_data : r_upper;
                        // the spare is consumed by this ack, so a new sample has nowhere to go
                        if (r_spare_v & w_acc) r_overflow <= 1'b1;
                    end else if (w_acc) begin
                        if (r_spare_v) r_overflow <= 1'b1;
                        else begin
                            r_spare   <= rx_data;
                            r_spare_v <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: vector table, multi-cycle corner sequences and a randomized
// run against a queue-based model of the packer.
module tb_sample_packer;
    localparam int MS = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, rx_valid = 1'b0, flush = 1'b0, mem_ack = 1'b0;
    logic [15:0] rx_data = '0;
    logic        mem_we, wrapped, overflow, busy;
    logic [31:0] mem_addr, mem_wdata, word_count;
    int          n_err = 0, n_chk = 0;

    sample_packer #(.MEM_SIZE(MS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx_valid(rx_valid), .rx_data(rx_data),
        .flush(flush), .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .wrapped(wrapped),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    logic [31:0] m_pend[$];
    logic [15:0] m_half[$];
    logic [15:0] m_spare[$];
    int          m_words, m_idx;
    bit          m_wrap, m_ovf;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic model_step(input bit acc, input logic [15:0] d, input bit fl, input bit ack);
        if (m_pend.size() != 0) begin
            if (ack) begin
                void'(m_pend.pop_front());
                m_words++;
                if (m_idx == MS - 1) m_wrap = 1;
                m_idx = (m_idx + 1) % MS;
                if (m_spare.size() != 0) begin
                    m_half.push_back(m_spare.pop_front());
                    if (acc) m_ovf = 1;
                end else if (acc) m_half.push_back(d);
            end else if (acc) begin
                if (m_spare.size() == 0) m_spare.push_back(d);
                else m_ovf = 1;
            end
        end else if (m_half.size() != 0) begin
            if (acc) m_pend.push_back({m_half.pop_front(), d});
            else if (fl) m_pend.push_back({m_half.pop_front(), 16'h0000});
        end else if (acc) m_half.push_back(d);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h5555, 16'hAAAA, 0, 32'h5555AAAA};
        vecs[1] = '{16'h1234, 16'hFFFF, 1, 32'h12340000};
        vecs[2] = '{16'hBEEF, 16'hCAFE, 2, 32'hBEEFCAFE};
        vecs[3] = '{16'h0001, 16'hFFFF, 0, 32'h0001FFFF};
        vecs[4] = '{16'hABCD, 16'h0000, 1, 32'hABCD0000};

        @(negedge clk);
        tick();
        tick();
        check("rst_we", {31'b0, mem_we}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", word_count, 0);
        check("rst_flags", {30'b0, wrapped, overflow}, 0);
        reset = 1'b1;
        enable = 1'b1;
        mem_ack = 1'b1;

        n = 0;
        for (int i = 0; i < 5; i++) begin
            strobe(vecs[i].a);
            check("half_busy", {31'b0, busy}, 1);
            check("half_we", {31'b0, mem_we}, 0);
            if (vecs[i].mode == 1) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end else begin
                flush = vecs[i].mode == 2;
                strobe(vecs[i].b);
                flush = 1'b0;
            end
            check("vec_we", {31'b0, mem_we}, 1);
            check("vec_wdata", mem_wdata, vecs[i].exp);
            check("vec_addr", mem_addr, BASE + 32'(n % MS));
            tick();
            n++;
            check("vec_we_low", {31'b0, mem_we}, 0);
            check("vec_idle", {31'b0, busy}, 0);
            check("vec_count", word_count, 32'(n));
            check("vec_wrapped", {31'b0, wrapped}, {31'b0, n >= MS});
        end

        mem_ack = 1'b0;
        strobe(16'h1111);
        strobe(16'h2222);
        check("stall_we", {31'b0, mem_we}, 1);
        strobe(16'h3333);
        check("spare_no_ovf", {31'b0, overflow}, 0);
        tick();
        strobe(16'h4444);
        strobe(16'h5555);
        for (int i = 0; i < 6; i++) tick();
        check("stall_ovf", {31'b0, overflow}, 1);
        check("stall_hold_we", {31'b0, mem_we}, 1);
        check("stall_hold_wdata", mem_wdata, 32'h11112222);
        check("stall_hold_addr", mem_addr, BASE + 32'd1);
        check("stall_count", word_count, 5);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("spare_we_low", {31'b0, mem_we}, 0);
        check("spare_half", {31'b0, busy}, 1);
        check("spare_count", word_count, 6);
        strobe(16'h6666);
        check("spare_wdata", mem_wdata, 32'h33336666);
        check("spare_addr", mem_addr, BASE + 32'd2);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("spare_done", {31'b0, busy}, 0);
        check("ovf_sticky", {31'b0, overflow}, 1);

        strobe(16'h7777);
        strobe(16'h8888);
        check("prerst_we", {31'b0, mem_we}, 1);
        reset = 1'b0;
        tick();
        check("wrst_we", {31'b0, mem_we}, 0);
        check("wrst_count", word_count, 0);
        check("wrst_flags", {30'b0, wrapped, overflow}, 0);
        check("wrst_busy", {31'b0, busy}, 0);
        check("wrst_addr", mem_addr, BASE);
        reset = 1'b1;

        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(16'(i + 16'h0A00));
            check("dis_we", {31'b0, mem_we}, 0);
            check("dis_busy", {31'b0, busy}, 0);
        end
        enable = 1'b1;
        strobe(16'h9999);
        check("en_half", {31'b0, busy}, 1);
        enable = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("dis_flush_we", {31'b0, mem_we}, 1);
        check("dis_flush_wdata", mem_wdata, 32'h99990000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("dis_flush_count", word_count, 1);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_pend.delete();
        m_half.delete();
        m_spare.delete();
        m_words = 0;
        m_idx = 0;
        m_wrap = 0;
        m_ovf = 0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_we", {31'b0, mem_we}, {31'b0, m_pend.size() != 0});
            check("rnd_busy", {31'b0, busy}, {31'b0, (m_pend.size() + m_half.size()) != 0});
            check("rnd_count", word_count, 32'(m_words));
            check("rnd_wrapped", {31'b0, wrapped}, {31'b0, m_wrap});
            check("rnd_overflow", {31'b0, overflow}, {31'b0, m_ovf});
            if (m_pend.size() != 0) begin
                check("rnd_wdata", mem_wdata, m_pend[0]);
                check("rnd_addr", mem_addr, BASE + 32'(m_idx));
            end
            enable   = $urandom_range(0, 9) != 0;
            rx_valid = $urandom_range(0, 9) < 4;
            rx_data  = 16'($urandom);
            flush    = $urandom_range(0, 9) == 0;
            mem_ack  = $urandom_range(0, 1) == 1;
            model_step(rx_valid & enable, rx_data, flush, mem_ack);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 4096, giving buffer depth in 32-bit words; the value SHALL be a power of two.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the word address of buffer entry 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock (100 MHz).
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: accept new samples when high.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe from the SPI receive stage marking a sample.
REQ-007 The block SHALL have port rx_data, input, 16 bits: received sensor sample, valid with rx_valid.
REQ-008 The block SHALL have port flush, input, 1 bit: force out a half-filled word.
REQ-009 The block SHALL have port mem_ack, input, 1 bit: data memory has accepted the current write.
REQ-010 The block SHALL have port mem_we, output, 1 bit: write request to the data memory.
REQ-011 The block SHALL have port mem_addr, output, 32 bits: write word address.
REQ-012 The block SHALL have port mem_wdata, output, 32 bits: packed write data.
REQ-013 The block SHALL have port word_count, output, 32 bits: number of words acknowledged since reset.
REQ-014 The block SHALL have ports wrapped, overflow and busy, each an output of 1 bit: two sticky status flags and a not-idle indicator.

Function
REQ-015 The block SHALL pack samples so that the first accepted sample goes to mem_wdata[31:16] and the second to [15:0].
REQ-016 The state machine SHALL have states EMPTY, HALF and WRITE; busy SHALL be high in any state other than EMPTY.
REQ-017 In EMPTY, rx_valid&enable SHALL capture the upper half and move to HALF; flush SHALL be ignored.
REQ-018 In HALF, rx_valid&enable SHALL capture the lower half and move to WRITE; mem_we SHALL rise on the next edge, giving 1-cycle latency.
REQ-019 In HALF, flush without rx_valid SHALL pad the lower half with 16'h0000 and move to WRITE.
REQ-020 When flush and rx_valid arrive together in HALF, the sample SHALL be used as the lower half with no padding.
REQ-021 In WRITE, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_ack is sampled high; mem_we SHALL go low on the following edge.
REQ-022 On ack, word_count SHALL increment by 1 (wrapping modulo 2^32) and the write pointer SHALL advance.
REQ-023 mem_addr SHALL equal BASE_ADDR + wr_ptr; wr_ptr SHALL wrap from MEM_SIZE-1 to 0, and wrapping SHALL set wrapped (sticky).
REQ-024 rx_valid&enable arriving in WRITE SHALL be held in a 1-deep spare register.
REQ-025 On ack with the spare full, the block SHALL go to HALF with the spare sample as the upper half and clear the spare; with the spare empty it SHALL go to EMPTY.
REQ-026 rx_valid&enable arriving in WRITE with the spare already full SHALL be dropped and SHALL set overflow (sticky).
REQ-027 rx_valid arriving on the same edge as mem_ack with the spare empty SHALL go into the spare, giving HALF next.
REQ-028 With enable low, rx_valid SHALL be ignored; a pending write and a held half SHALL be retained, and flush SHALL still act.
REQ-029 mem_ack sampled outside WRITE SHALL be ignored.

Reset
REQ-030 With reset low at a clk edge, the state SHALL become EMPTY, the spare invalid and wr_ptr 0.
REQ-031 Under reset, mem_we, word_count, wrapped, overflow and busy SHALL be 0, mem_addr SHALL be BASE_ADDR and mem_wdata SHALL be 0.
REQ-032 Reset during WRITE SHALL drop the word and deassert mem_we on that edge without waiting for mem_ack.

Structure
REQ-033 A shared package sample_pkg SHALL hold the state enum, SAMPLE_W=16, WORD_W=32 and PAD_HALF=16'h0000.
REQ-034 The block SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-035 Samples 16'h5555 and 16'hAAAA, mem_ack tied high -> mem_we pulses one cycle after the second strobe with wdata 32'h5555AAAA, addr BASE_ADDR, and word_count becomes 1.
REQ-036 One sample 16'h1234 then flush -> wdata 32'h12340000 written, state returns to EMPTY.
REQ-037 mem_ack held low for 10 cycles while 3 samples arrive -> the first is kept in the spare, the next two are dropped, overflow=1; after ack the block is in HALF with the spare sample as the upper half.
REQ-038 MEM_SIZE=4, 5 words written -> addresses 0,1,2,3,0 in order, wrapped=1 after the fourth ack.
REQ-039 Reset asserted while mem_we=1 -> mem_we=0 at the next edge, word_count=0, all flags clear.
REQ-040 enable=0 with 4 strobes -> no mem_we and busy stays 0; a strobe after enable=1 -> HALF.
